// File: rtl/pci_tx_pkg.sv
// Shared types and constants for the PCI transmit path VC scheduling logic.
// Holds the arbiter state encoding, VC identifiers and the default word width.
package pci_tx_pkg;

    localparam int DEFAULT_DATA_WIDTH = 6;

    localparam logic VC0_ID = 1'b0;
    localparam logic VC1_ID = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE_VC0 = 2'd1,
        SERVE_VC1 = 2'd2
    } arb_state_t;

    // Grant credit decrement that parks at zero while a lone VC keeps being served.
    function automatic logic [2:0] credit_dec_sat(input logic [2:0] credit);
        logic [2:0] result;
        if (credit == 3'd0) begin
            result = 3'd0;
        end else begin
            result = credit - 3'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/vc_pop_arbiter.sv
// Weighted round-robin pop scheduler for the VC0/VC1 transmit FIFOs with a
// registered capture stage that tags each popped word with its source VC.
module vc_pop_arbiter
    import pci_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int WEIGHT_VC0 = 3,
    parameter int WEIGHT_VC1 = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  empty_fifo_VC0,
    input  logic                  almost_empty_fifo_VC0,
    input  logic [DATA_WIDTH-1:0] data_out_VC0,
    input  logic                  empty_fifo_VC1,
    input  logic                  almost_empty_fifo_VC1,
    input  logic [DATA_WIDTH-1:0] data_out_VC1,
    input  logic                  pause,
    output logic                  pop_VC0_fifo,
    output logic                  pop_VC1_fifo,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  vc_id
);

    localparam logic [2:0] RELOAD_VC0 = 3'(WEIGHT_VC0 - 1);
    localparam logic [2:0] RELOAD_VC1 = 3'(WEIGHT_VC1 - 1);

    arb_state_t            state_q;
    arb_state_t            state_d;
    logic [2:0]            credit_q;
    logic [2:0]            credit_d;
    logic                  pop_vc0_q;
    logic                  pop_vc0_d;
    logic                  pop_vc1_q;
    logic                  pop_vc1_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  vc_id_q;
    logic                  elig_vc0_s;
    logic                  elig_vc1_s;

    // A FIFO showing its last word while we already pop it has nothing left to offer,
    // because its flags only catch up one cycle after the pop.
    assign elig_vc0_s = !empty_fifo_VC0 && !(pop_vc0_q && almost_empty_fifo_VC0);
    assign elig_vc1_s = !empty_fifo_VC1 && !(pop_vc1_q && almost_empty_fifo_VC1);

    // Next-state, credit and pop decision for the weighted round-robin.
    always_comb begin
        state_d   = state_q;
        credit_d  = credit_q;
        pop_vc0_d = 1'b0;
        pop_vc1_d = 1'b0;
        if (pause) begin
            state_d  = state_q;
            credit_d = credit_q;
        end else begin
            case (state_q)
                IDLE: begin
                    if (elig_vc0_s) begin
                        state_d   = SERVE_VC0;
                        credit_d  = RELOAD_VC0;
                        pop_vc0_d = 1'b1;
                    end else if (elig_vc1_s) begin
                        state_d   = SERVE_VC1;
                        credit_d  = RELOAD_VC1;
                        pop_vc1_d = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        credit_d = 3'd0;
                    end
                end
                SERVE_VC0: begin
                    if (elig_vc0_s && ((credit_q != 3'd0) || !elig_vc1_s)) begin
                        credit_d  = credit_dec_sat(credit_q);
                        pop_vc0_d = 1'b1;
                    end else if (elig_vc1_s) begin
                        state_d   = SERVE_VC1;
                        credit_d  = RELOAD_VC1;
                        pop_vc1_d = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        credit_d = 3'd0;
                    end
                end
                SERVE_VC1: begin
                    if (elig_vc1_s && ((credit_q != 3'd0) || !elig_vc0_s)) begin
                        credit_d  = credit_dec_sat(credit_q);
                        pop_vc1_d = 1'b1;
                    end else if (elig_vc0_s) begin
                        state_d   = SERVE_VC0;
                        credit_d  = RELOAD_VC0;
                        pop_vc0_d = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        credit_d = 3'd0;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    credit_d = 3'd0;
                end
            endcase
        end
    end

    // Arbiter state, credit and registered pop strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            credit_q  <= 3'd0;
            pop_vc0_q <= 1'b0;
            pop_vc1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            credit_q  <= credit_d;
            pop_vc0_q <= pop_vc0_d;
            pop_vc1_q <= pop_vc1_d;
        end
    end

    // Capture stage: the registered pop strobes are the one-cycle-delayed pop
    // flags that select which FIFO's read data lands in the output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= {DATA_WIDTH{1'b0}};
            valid_q <= 1'b0;
            vc_id_q <= VC0_ID;
        end else begin
            valid_q <= pop_vc0_q | pop_vc1_q;
            if (pop_vc0_q) begin
                data_q  <= data_out_VC0;
                vc_id_q <= VC0_ID;
            end else if (pop_vc1_q) begin
                data_q  <= data_out_VC1;
                vc_id_q <= VC1_ID;
            end else begin
                data_q  <= data_q;
                vc_id_q <= vc_id_q;
            end
        end
    end

    assign pop_VC0_fifo = pop_vc0_q;
    assign pop_VC1_fifo = pop_vc1_q;
    assign data_out     = data_q;
    assign valid_out    = valid_q;
    assign vc_id        = vc_id_q;

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Bench for vc_pop_arbiter: behavioural FIFO pair, weighted round-robin
// reference model and a scoreboard checked by an independent output monitor.
module tb_vc_pop_arbiter;

    localparam int DW = 6;
    localparam int W0 = 3;
    localparam int W1 = 1;

    typedef struct packed {
        logic          vc;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          empty_fifo_VC0;
    logic          almost_empty_fifo_VC0;
    logic [DW-1:0] data_out_VC0;
    logic          empty_fifo_VC1;
    logic          almost_empty_fifo_VC1;
    logic [DW-1:0] data_out_VC1;
    logic          pause;
    logic          pop_VC0_fifo;
    logic          pop_VC1_fifo;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          vc_id;

    exp_t          sb[$];
    logic [DW-1:0] fifo0[$];
    logic [DW-1:0] fifo1[$];
    logic [DW-1:0] ref0[$];
    logic [DW-1:0] ref1[$];

    int         tests   = 0;
    int         fails   = 0;
    logic [1:0] exp_pop = 2'b00;
    logic       seen0   = 1'b0;
    logic       seen1   = 1'b0;
    int         last_vc = -1;
    int         run_len = 0;
    bit         mon_en  = 1'b0;

    always #5 clk = ~clk;

    vc_pop_arbiter #(
        .DATA_WIDTH (DW),
        .WEIGHT_VC0 (W0),
        .WEIGHT_VC1 (W1)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .empty_fifo_VC0        (empty_fifo_VC0),
        .almost_empty_fifo_VC0 (almost_empty_fifo_VC0),
        .data_out_VC0          (data_out_VC0),
        .empty_fifo_VC1        (empty_fifo_VC1),
        .almost_empty_fifo_VC1 (almost_empty_fifo_VC1),
        .data_out_VC1          (data_out_VC1),
        .pause                 (pause),
        .pop_VC0_fifo          (pop_VC0_fifo),
        .pop_VC1_fifo          (pop_VC1_fifo),
        .data_out              (data_out),
        .valid_out             (valid_out),
        .vc_id                 (vc_id)
    );

    function automatic void chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    // Output monitor: every valid word must match the oldest outstanding grant.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && valid_out) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_valid: got valid_out=1 data=%0d expected no output at %0t",
                         data_out, $time);
            end else begin
                e = sb.pop_front();
                chk("vc_id", int'(vc_id), int'(e.vc));
                chk("data_out", int'(data_out), int'(e.data));
            end
        end
    end

    // One clock cycle: update FIFOs, drive inputs, run the model, check pops.
    task automatic step(input bit rst, input bit pz, input int n0, input int n1);
        logic [1:0]    g;
        int            pick;
        int            wt;
        bit            e0;
        bit            e1;
        logic [DW-1:0] w;
        g = 2'b00;
        if (seen0) begin
            if (fifo0.size() > 0) void'(fifo0.pop_front());
            else chk("pop_empty_VC0", 1, 0);
        end
        if (seen1) begin
            if (fifo1.size() > 0) void'(fifo1.pop_front());
            else chk("pop_empty_VC1", 1, 0);
        end
        for (int i = 0; i < n0; i++) begin
            w = DW'($urandom);
            fifo0.push_back(w);
            ref0.push_back(w);
        end
        for (int i = 0; i < n1; i++) begin
            w = DW'($urandom);
            fifo1.push_back(w);
            ref1.push_back(w);
        end
        reset                 = rst;
        pause                 = pz;
        empty_fifo_VC0        = (fifo0.size() == 0);
        almost_empty_fifo_VC0 = (fifo0.size() <= 1);
        data_out_VC0          = (fifo0.size() > 0) ? fifo0[0] : DW'($urandom);
        empty_fifo_VC1        = (fifo1.size() == 0);
        almost_empty_fifo_VC1 = (fifo1.size() <= 1);
        data_out_VC1          = (fifo1.size() > 0) ? fifo1[0] : DW'($urandom);

        // Model: a VC is a candidate while it still has unclaimed words; with two
        // candidates the current VC keeps the grant until its run reaches its weight.
        if (rst) begin
            if (exp_pop != 2'b00 && sb.size() > 0) void'(sb.pop_back());
            last_vc = -1;
            run_len = 0;
        end else if (!pz) begin
            e0 = (ref0.size() > 0);
            e1 = (ref1.size() > 0);
            pick = -1;
            if (e0 && e1) begin
                wt = (last_vc == 1) ? W1 : W0;
                if (last_vc < 0) pick = 0;
                else if (run_len < wt) pick = last_vc;
                else pick = 1 - last_vc;
            end else if (e0) begin
                pick = 0;
            end else if (e1) begin
                pick = 1;
            end
            if (pick < 0) begin
                last_vc = -1;
                run_len = 0;
            end else begin
                if (pick == last_vc) run_len++;
                else begin
                    last_vc = pick;
                    run_len = 1;
                end
                if (pick == 0) begin
                    sb.push_back('{vc: 1'b0, data: ref0.pop_front()});
                    g = 2'b01;
                end else begin
                    sb.push_back('{vc: 1'b1, data: ref1.pop_front()});
                    g = 2'b10;
                end
            end
        end

        @(negedge clk);
        chk("pop_VC0_fifo", int'(pop_VC0_fifo), int'(exp_pop[0]));
        chk("pop_VC1_fifo", int'(pop_VC1_fifo), int'(exp_pop[1]));
        seen0 = pop_VC0_fifo;
        seen1 = pop_VC1_fifo;
        @(posedge clk);
        #1;
        exp_pop = g;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        int k;
        reset                 = 1'b1;
        pause                 = 1'b0;
        empty_fifo_VC0        = 1'b1;
        almost_empty_fifo_VC0 = 1'b1;
        data_out_VC0          = '0;
        empty_fifo_VC1        = 1'b1;
        almost_empty_fifo_VC1 = 1'b1;
        data_out_VC1          = '0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reset held with data in both FIFOs: everything stays at zero.
        step(1'b1, 1'b0, 3, 3);
        step(1'b1, 1'b0, 0, 0);
        chk("rst_valid_out", int'(valid_out), 0);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_vc_id", int'(vc_id), 0);
        idle_cycles(12);

        // Lone VC0 burst.
        step(1'b0, 1'b0, 8, 0);
        idle_cycles(12);

        // Both VCs loaded: 3:1 interleave, then VC0 alone.
        step(1'b0, 1'b0, 8, 8);
        idle_cycles(22);

        // Single word in VC1.
        step(1'b0, 1'b0, 0, 1);
        idle_cycles(5);

        // Pause for four cycles in the middle of a mixed stream.
        step(1'b0, 1'b0, 8, 8);
        idle_cycles(2);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 0, 0);
        idle_cycles(20);

        // Reset landing on a VC1 pop cycle.
        step(1'b0, 1'b0, 5, 5);
        k = 0;
        while (exp_pop != 2'b10 && k < 20) begin
            step(1'b0, 1'b0, 0, 0);
            k++;
        end
        if (exp_pop != 2'b10) begin
            tests++;
            fails++;
            $display("FAIL reach_vc1_pop: got no VC1 pop within 20 cycles expected one");
        end
        step(1'b1, 1'b0, 0, 0);
        idle_cycles(20);

        // Randomized traffic with random pause.
        for (int i = 0; i < 400; i++) begin
            step(1'b0, ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : 0,
                 ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : 0);
        end
        idle_cycles(40);

        chk("scoreboard_drained", sb.size(), 0);
        chk("fifo0_drained", fifo0.size(), 0);
        chk("fifo1_drained", fifo1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

endmodule
